// File: rtl/oam_dma.sv
// Game Boy OAM DMA bus initiator: a write to the DMA register copies
// LENGTH bytes from {src_hi,8'h00} to DEST_BASE, one read + one write per byte.
module oam_dma #(
    parameter logic [15:0] REG_ADDR  = 16'hFF46,
    parameter logic [15:0] DEST_BASE = 16'hFE00,
    parameter int          LENGTH    = 160
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_w,
    input  logic        cpu_write_enable,
    output logic [7:0]  cpu_data_r,
    output logic        cpu_data_active,
    output logic [15:0] dma_addr,
    input  logic [7:0]  dma_data_r,
    output logic [7:0]  dma_data_w,
    output logic        dma_write_enable,
    output logic        dma_active
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;

    localparam logic [7:0] LAST = 8'(LENGTH - 1);

    logic [1:0] state;
    logic [7:0] src_hi;
    logic [7:0] idx;
    logic [7:0] data_buf;
    logic       reg_hit;
    logic       reg_write;

    assign reg_hit         = (cpu_addr == REG_ADDR);
    assign reg_write       = cpu_write_enable && reg_hit;
    assign cpu_data_active = !cpu_write_enable && reg_hit;

    // A register write always wins, even on the final WRITE edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            src_hi   <= 8'hFF;
            idx      <= 8'h00;
            data_buf <= 8'h00;
        end else if (reg_write) begin
            src_hi <= cpu_data_w;
            idx    <= 8'h00;
            state  <= READ;
        end else begin
            case (state)
                READ: begin
                    data_buf <= dma_data_r;
                    state    <= WRITE;
                end
                WRITE: begin
                    if (idx == LAST) begin
                        state <= IDLE;
                    end else begin
                        idx   <= idx + 8'd1;
                        state <= READ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_data_r <= 8'hFF;
        end else if (reg_hit) begin
            cpu_data_r <= src_hi;
        end
    end

    // Outputs are pure decodes of state so async reset clears them at once.
    always_comb begin
        dma_active       = 1'b0;
        dma_write_enable = 1'b0;
        dma_addr         = 16'h0000;
        dma_data_w       = data_buf;
        case (state)
            READ: begin
                dma_active = 1'b1;
                dma_addr   = {src_hi, idx};
            end
            WRITE: begin
                dma_active       = 1'b1;
                dma_write_enable = 1'b1;
                dma_addr         = DEST_BASE + {8'h00, idx};
            end
            default: begin
                dma_active = 1'b0;
            end
        endcase
    end

endmodule
